lbp_frame_writer: RTL and testbench

- Upstream neighbour of the VGA display top. Accepts a streaming 8-bit pixel (grayscale or LBP code) and expands it to 12-bit RGB444.
- Writes each pixel sequentially into port A of the 400x300 display frame buffer. The VGA stage reads port B of the same buffer.
- Drives the `all_ready` flag that releases the VGA read address counter once one complete frame has been stored.

---
 rtl/lbp_frame_writer.sv | 163 ++++++++++++++++
 tb/tb_lbp_frame_writer.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lbp_frame_writer.sv
// Streams 8-bit pixels into the display frame buffer as RGB444 and raises all_ready after the first full frame.
// Optional FRAME_ERR_CNT_EN adds a saturating frame_err counter (err_cnt) with a synchronous clear (err_clr).
module lbp_frame_writer #(
    parameter int unsigned H_RES  = 400,
    parameter int unsigned V_RES  = 300,
    parameter int unsigned ADDR_W = 17
) (
    input  logic              clk_25mHz,
    input  logic              rst,
    input  logic [7:0]        s_data,
    input  logic              s_valid,
    input  logic              s_sof,
    output logic              s_ready,
    output logic              bram_we,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [11:0]       bram_din,
    output logic              all_ready,
    output logic              frame_err,
    output logic              busy
`ifdef FRAME_ERR_CNT_EN
    ,
    input  logic              err_clr,
    output logic [7:0]        err_cnt
`endif
);

    localparam int unsigned PIX_TOTAL = H_RES * V_RES;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PIX_TOTAL - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FILL   = 2'd1,
        COMMIT = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [11:0]         din_q, din_d;
    logic                we_q, we_d;
    logic                ready_q, ready_d;
    logic                busy_q, busy_d;
    logic                all_ready_q, all_ready_d;
    logic                err_q, err_d;

    logic                xfer_c;
    logic [11:0]         rgb_c;
    logic                lsb_unused_c;

    assign xfer_c       = s_valid & ready_q;
    // Grayscale/LBP code keeps only its upper nibble on all three channels.
    assign rgb_c        = {s_data[7:4], s_data[7:4], s_data[7:4]};
    assign lsb_unused_c = ^s_data[3:0];

    always_ff @(posedge clk_25mHz) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (xfer_c && s_sof) state_d = FILL;
            FILL:    if (xfer_c && !s_sof && (cnt_q == LAST_ADDR)) state_d = COMMIT;
            COMMIT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Registered outputs are decoded from the next state so they line up with state_q.
    always_comb begin
        we_d        = 1'b0;
        addr_d      = addr_q;
        din_d       = din_q;
        cnt_d       = cnt_q;
        err_d       = 1'b0;
        all_ready_d = all_ready_q;
        ready_d     = (state_d != COMMIT);
        busy_d      = (state_d != IDLE);
        case (state_q)
            IDLE: begin
                if (xfer_c && s_sof) begin
                    we_d   = 1'b1;
                    addr_d = '0;
                    din_d  = rgb_c;
                    cnt_d  = ADDR_W'(1);
                end
            end
            FILL: begin
                if (xfer_c) begin
                    we_d  = 1'b1;
                    din_d = rgb_c;
                    if (s_sof) begin
                        err_d  = 1'b1;
                        addr_d = '0;
                        cnt_d  = ADDR_W'(1);
                    end else begin
                        addr_d = cnt_q;
                        cnt_d  = cnt_q + ADDR_W'(1);
                    end
                end
            end
            COMMIT: begin
                all_ready_d = 1'b1;
                cnt_d       = '0;
            end
            default: begin
                cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk_25mHz) begin
        if (rst) begin
            cnt_q       <= '0;
            addr_q      <= '0;
            din_q       <= '0;
            we_q        <= 1'b0;
            ready_q     <= 1'b0;
            busy_q      <= 1'b0;
            all_ready_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            din_q       <= din_d;
            we_q        <= we_d;
            ready_q     <= ready_d;
            busy_q      <= busy_d;
            all_ready_q <= all_ready_d;
            err_q       <= err_d;
        end
    end

    assign s_ready   = ready_q;
    assign bram_we   = we_q;
    assign bram_addr = addr_q;
    assign bram_din  = din_q;
    assign all_ready = all_ready_q;
    assign frame_err = err_q;
    assign busy      = busy_q;

`ifdef FRAME_ERR_CNT_EN
    logic [7:0] err_cnt_q;

    // Clear wins over a coincident frame_err pulse; count saturates at 255.
    always_ff @(posedge clk_25mHz) begin
        if (rst) begin
            err_cnt_q <= 8'd0;
        end else if (err_clr) begin
            err_cnt_q <= 8'd0;
        end else if (err_q && (err_cnt_q != 8'hFF)) begin
            err_cnt_q <= err_cnt_q + 8'd1;
        end
    end

    assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_lbp_frame_writer.sv
// Directed self-checking bench for lbp_frame_writer, run on a reduced 20x10 frame.
// Builds with or without FRAME_ERR_CNT_EN.
module tb_lbp_frame_writer;

    localparam int unsigned TB_H = 20;
    localparam int unsigned TB_V = 10;
    localparam int unsigned TOT  = TB_H * TB_V;

    logic        clk;
    logic        rst;
    logic [7:0]  s_data;
    logic        s_valid;
    logic        s_sof;
    logic        s_ready;
    logic        bram_we;
    logic [16:0] bram_addr;
    logic [11:0] bram_din;
    logic        all_ready;
    logic        frame_err;
    logic        busy;
`ifdef FRAME_ERR_CNT_EN
    logic        err_clr;
    logic [7:0]  err_cnt;
`endif

    int total = 0;
    int bad   = 0;

    logic [16:0] wa_q[$];
    logic [11:0] wd_q[$];
    int          err_pulses = 0;
    int          ar_rise    = 0;
    logic        ar_prev    = 1'b0;

    lbp_frame_writer #(
        .H_RES (TB_H),
        .V_RES (TB_V),
        .ADDR_W(17)
    ) dut (
        .clk_25mHz(clk),
        .rst      (rst),
        .s_data   (s_data),
        .s_valid  (s_valid),
        .s_sof    (s_sof),
        .s_ready  (s_ready),
        .bram_we  (bram_we),
        .bram_addr(bram_addr),
        .bram_din (bram_din),
        .all_ready(all_ready),
        .frame_err(frame_err),
        .busy     (busy)
`ifdef FRAME_ERR_CNT_EN
        ,
        .err_clr  (err_clr),
        .err_cnt  (err_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Passive log of buffer writes and flag events, sampled mid-cycle.
    always @(negedge clk) begin
        if (bram_we === 1'b1) begin
            wa_q.push_back(bram_addr);
            wd_q.push_back(bram_din);
        end
        if (frame_err === 1'b1) err_pulses++;
        if (all_ready === 1'b1 && ar_prev !== 1'b1) ar_rise++;
        ar_prev = all_ready;
    end

    function automatic logic [11:0] rgb(input logic [7:0] d);
        return {d[7:4], d[7:4], d[7:4]};
    endfunction

    task automatic clear_log();
        wa_q.delete();
        wd_q.delete();
        err_pulses = 0;
        ar_rise    = 0;
    endtask

    // Offer one pixel until it is accepted (optionally with random valid gaps).
    task automatic push_px(input logic [7:0] d, input logic sof, input bit rnd);
        int  guard;
        bit  done;
        guard = 0;
        done  = 1'b0;
        while (!done) begin
            @(negedge clk);
            s_data  = d;
            s_sof   = sof;
            s_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            done    = s_valid && (s_ready === 1'b1);
            guard++;
            if (!done && guard > 100) begin
                total++;
                bad++;
                $display("FAIL push_timeout: s_ready=%b, required 1 within 100 cycles", s_ready);
                done = 1'b1;
            end
        end
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(negedge clk);
            s_valid = 1'b0;
            s_sof   = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst     = 1'b1;
        s_valid = 1'b0;
        s_sof   = 1'b0;
`ifdef FRAME_ERR_CNT_EN
        err_clr = 1'b0;
`endif
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1; s_valid = 1'b1; s_sof = 1'b1; s_data = 8'hFF;
        @(negedge clk);
        total++; if (s_ready   !== 1'b0)  begin bad++; $display("FAIL rst_s_ready got=%b exp=0", s_ready); end
        total++; if (bram_we   !== 1'b0)  begin bad++; $display("FAIL rst_we got=%b exp=0", bram_we); end
        total++; if (bram_addr !== 17'd0) begin bad++; $display("FAIL rst_addr got=%0d exp=0", bram_addr); end
        total++; if (bram_din  !== 12'h0) begin bad++; $display("FAIL rst_din got=%h exp=000", bram_din); end
        total++; if (all_ready !== 1'b0)  begin bad++; $display("FAIL rst_all_ready got=%b exp=0", all_ready); end
        total++; if (frame_err !== 1'b0)  begin bad++; $display("FAIL rst_frame_err got=%b exp=0", frame_err); end
        total++; if (busy      !== 1'b0)  begin bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
        rst = 1'b0; s_valid = 1'b0; s_sof = 1'b0;
        @(negedge clk);
        total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL rst_release_ready got=%b exp=1", s_ready); end
        total++; if (busy    !== 1'b0) begin bad++; $display("FAIL rst_release_busy got=%b exp=0", busy); end
    endtask

    task automatic test_drop_pre_sof();
        #1 clear_log();
        for (int i = 0; i < 5; i++) push_px(8'h55, 1'b0, 1'b0);
        idle_cycles(2);
        total++; if (wa_q.size() != 0) begin bad++; $display("FAIL pre_sof_writes got=%0d exp=0", wa_q.size()); end
        total++; if (busy !== 1'b0)    begin bad++; $display("FAIL pre_sof_busy got=%b exp=0", busy); end
        push_px(8'hA7, 1'b1, 1'b0);
        @(negedge clk);
        total++; if (bram_we   !== 1'b1)   begin bad++; $display("FAIL sof_we got=%b exp=1", bram_we); end
        total++; if (bram_addr !== 17'd0)  begin bad++; $display("FAIL sof_addr got=%0d exp=0", bram_addr); end
        total++; if (bram_din  !== 12'hAAA) begin bad++; $display("FAIL colour_a7 got=%h exp=aaa", bram_din); end
        total++; if (busy      !== 1'b1)   begin bad++; $display("FAIL sof_busy got=%b exp=1", busy); end
        s_data = 8'h0F; s_sof = 1'b0; s_valid = 1'b1;
        @(negedge clk);
        s_valid = 1'b0;
        total++; if (bram_addr !== 17'd1)  begin bad++; $display("FAIL second_addr got=%0d exp=1", bram_addr); end
        total++; if (bram_din  !== 12'h000) begin bad++; $display("FAIL colour_0f got=%h exp=000", bram_din); end
    endtask

    // Continues the frame left at address 1 by the previous test.
    task automatic test_early_sof();
        int nbad;
        for (int i = 2; i < 50; i++) push_px(8'(i), 1'b0, 1'b0);
        idle_cycles(1);
        #1 clear_log();
        push_px(8'h11, 1'b1, 1'b0);
        @(negedge clk);
        s_valid = 1'b0;
        total++; if (frame_err !== 1'b1)  begin bad++; $display("FAIL early_sof_err got=%b exp=1", frame_err); end
        total++; if (bram_addr !== 17'd0) begin bad++; $display("FAIL early_sof_addr got=%0d exp=0", bram_addr); end
        total++; if (bram_we   !== 1'b1)  begin bad++; $display("FAIL early_sof_we got=%b exp=1", bram_we); end
        @(negedge clk);
        total++; if (frame_err !== 1'b0)  begin bad++; $display("FAIL early_sof_pulse_width got=%b exp=0", frame_err); end
        for (int i = 1; i < TOT; i++) push_px(8'(i), 1'b0, 1'b0);
        @(negedge clk);
        s_valid = 1'b0;
        total++; if (s_ready   !== 1'b0) begin bad++; $display("FAIL early_commit_ready got=%b exp=0", s_ready); end
        total++; if (all_ready !== 1'b0) begin bad++; $display("FAIL early_all_ready_held got=%b exp=0", all_ready); end
        @(negedge clk);
        total++; if (all_ready !== 1'b1) begin bad++; $display("FAIL early_all_ready_set got=%b exp=1", all_ready); end
        nbad = 0;
        for (int i = 0; i < wa_q.size(); i++) if (wa_q[i] !== 17'(i)) nbad++;
        total++; if (wa_q.size() != TOT || nbad != 0) begin
            bad++; $display("FAIL early_addr_seq writes=%0d exp=%0d bad_addr=%0d exp=0", wa_q.size(), TOT, nbad);
        end
        total++; if (err_pulses != 1) begin bad++; $display("FAIL early_err_count got=%0d exp=1", err_pulses); end
    endtask

    task automatic test_back_to_back();
        int nbad;
        do_reset();
        clear_log();
        for (int i = 0; i < TOT; i++) push_px(8'(i), (i == 0), 1'b0);
        @(negedge clk);
        s_data = 8'hEE; s_sof = 1'b0; s_valid = 1'b1;
        total++; if (s_ready   !== 1'b0)        begin bad++; $display("FAIL b2b_commit_ready got=%b exp=0", s_ready); end
        total++; if (bram_we   !== 1'b1)        begin bad++; $display("FAIL b2b_last_we got=%b exp=1", bram_we); end
        total++; if (bram_addr !== 17'(TOT - 1)) begin bad++; $display("FAIL b2b_last_addr got=%0d exp=%0d", bram_addr, TOT - 1); end
        total++; if (busy      !== 1'b1)        begin bad++; $display("FAIL b2b_commit_busy got=%b exp=1", busy); end
        total++; if (all_ready !== 1'b0)        begin bad++; $display("FAIL b2b_all_ready_early got=%b exp=0", all_ready); end
        @(negedge clk);
        total++; if (s_ready   !== 1'b1) begin bad++; $display("FAIL b2b_idle_ready got=%b exp=1", s_ready); end
        total++; if (all_ready !== 1'b1) begin bad++; $display("FAIL b2b_all_ready got=%b exp=1", all_ready); end
        total++; if (busy      !== 1'b0) begin bad++; $display("FAIL b2b_idle_busy got=%b exp=0", busy); end
        total++; if (bram_we   !== 1'b0) begin bad++; $display("FAIL b2b_commit_no_we got=%b exp=0", bram_we); end
        @(negedge clk);
        s_valid = 1'b0;
        total++; if (bram_we !== 1'b0) begin bad++; $display("FAIL b2b_extra_dropped got=%b exp=0", bram_we); end
        nbad = 0;
        for (int i = 0; i < wa_q.size(); i++)
            if (wa_q[i] !== 17'(i) || wd_q[i] !== rgb(8'(i))) nbad++;
        total++; if (wa_q.size() != TOT || nbad != 0) begin
            bad++; $display("FAIL b2b_writes count=%0d exp=%0d bad_entries=%0d exp=0", wa_q.size(), TOT, nbad);
        end
    endtask

    task automatic test_random_valid();
        int nbad;
        do_reset();
        clear_log();
        for (int f = 0; f < 2; f++)
            for (int i = 0; i < TOT; i++) push_px(8'(i), (i == 0), 1'b1);
        idle_cycles(3);
        total++; if (wa_q.size() != 2 * TOT) begin bad++; $display("FAIL rnd_write_count got=%0d exp=%0d", wa_q.size(), 2 * TOT); end
        total++; if (ar_rise != 1)    begin bad++; $display("FAIL rnd_all_ready_rises got=%0d exp=1", ar_rise); end
        total++; if (all_ready !== 1'b1) begin bad++; $display("FAIL rnd_all_ready got=%b exp=1", all_ready); end
        total++; if (err_pulses != 0) begin bad++; $display("FAIL rnd_frame_err got=%0d exp=0", err_pulses); end
        nbad = 0;
        for (int i = 0; i < wa_q.size(); i++)
            if (wa_q[i] !== 17'(i % TOT) || wd_q[i] !== rgb(8'(i % TOT))) nbad++;
        total++; if (nbad != 0) begin bad++; $display("FAIL rnd_write_contents bad_entries=%0d exp=0", nbad); end
    endtask

    task automatic test_reset_mid_frame();
        for (int i = 0; i < TOT / 2; i++) push_px(8'(i), (i == 0), 1'b0);
        @(negedge clk);
        s_valid = 1'b0;
        total++; if (all_ready !== 1'b1) begin bad++; $display("FAIL mid_pre_all_ready got=%b exp=1", all_ready); end
        rst = 1'b1;
        @(negedge clk);
        total++; if (s_ready   !== 1'b0)  begin bad++; $display("FAIL mid_rst_ready got=%b exp=0", s_ready); end
        total++; if (bram_we   !== 1'b0)  begin bad++; $display("FAIL mid_rst_we got=%b exp=0", bram_we); end
        total++; if (bram_addr !== 17'd0) begin bad++; $display("FAIL mid_rst_addr got=%0d exp=0", bram_addr); end
        total++; if (bram_din  !== 12'h0) begin bad++; $display("FAIL mid_rst_din got=%h exp=000", bram_din); end
        total++; if (all_ready !== 1'b0)  begin bad++; $display("FAIL mid_rst_all_ready got=%b exp=0", all_ready); end
        total++; if (frame_err !== 1'b0)  begin bad++; $display("FAIL mid_rst_frame_err got=%b exp=0", frame_err); end
        total++; if (busy      !== 1'b0)  begin bad++; $display("FAIL mid_rst_busy got=%b exp=0", busy); end
        rst = 1'b0;
        @(negedge clk);
        #1 clear_log();
        push_px(8'h3C, 1'b1, 1'b0);
        idle_cycles(2);
        total++; if (wa_q.size() != 1) begin
            bad++; $display("FAIL mid_restart_count got=%0d exp=1", wa_q.size());
        end else begin
            total++; if (wa_q[0] !== 17'd0 || wd_q[0] !== 12'h333) begin
                bad++; $display("FAIL mid_restart_write got=%0d/%h exp=0/333", wa_q[0], wd_q[0]);
            end
        end
    endtask

`ifdef FRAME_ERR_CNT_EN
    task automatic test_err_cnt();
        do_reset();
        total++; if (err_cnt !== 8'd0) begin bad++; $display("FAIL errcnt_reset got=%0d exp=0", err_cnt); end
        push_px(8'h01, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) push_px(8'h02, 1'b1, 1'b0);
        idle_cycles(3);
        total++; if (err_cnt !== 8'd3) begin bad++; $display("FAIL errcnt_three got=%0d exp=3", err_cnt); end
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        total++; if (err_cnt !== 8'd0) begin bad++; $display("FAIL errcnt_clear got=%0d exp=0", err_cnt); end
    endtask
`endif

    initial begin
        rst = 1'b1; s_valid = 1'b0; s_sof = 1'b0; s_data = 8'h00;
`ifdef FRAME_ERR_CNT_EN
        err_clr = 1'b0;
`endif
        repeat (2) @(negedge clk);
        test_reset();
        test_drop_pre_sof();
        test_early_sof();
        test_back_to_back();
        test_random_valid();
        test_reset_mid_frame();
`ifdef FRAME_ERR_CNT_EN
        test_err_cnt();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
        $fatal(1);
    end

endmodule
